// File: rtl/led_count_ctrl_pkg.sv
// Shared constants, vector types and the controller state encoding for the
// LED-count sequencer and its rounding-fixup helper.
package led_count_pkg;

  localparam int W       = 6;
  localparam int D       = 10;
  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int TIMEOUT = 16;

  localparam int AW    = W + D;
  localparam int CW    = $clog2(LEDS);
  localparam int SUMW  = W + D + $clog2(BIN_QTY);
  localparam int IDXW  = $clog2(BIN_QTY);
  localparam int TOTW  = CW + $clog2(BIN_QTY);
  localparam int DIFFW = TOTW + 1;
  localparam int TMOW  = $clog2(TIMEOUT);

  typedef logic [BIN_QTY-1:0][CW-1:0] count_vec_t;
  typedef logic [BIN_QTY-1:0][AW-1:0] amp_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SUM,
    FIX,
    OUT
  } state_t;

  // Bin index increment with wrap from BIN_QTY-1 back to 0.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (i == IDXW'(BIN_QTY - 1)) ? '0 : i + IDXW'(1);
  endfunction

endpackage

// File: rtl/led_count_ctrl_if.sv
// Bundle of the upstream frame, divider and downstream LED-count handshakes.
interface led_count_ctrl_if;
  import led_count_pkg::*;

  logic             in_valid;
  logic             in_ready;
  amp_vec_t         amps_i;
  logic [SUMW-1:0]  amp_sum_i;

  logic             calc_start;
  amp_vec_t         calc_amps;
  logic [SUMW-1:0]  calc_sum;
  count_vec_t       calc_count;
  logic             calc_valid;

  logic             out_valid;
  logic             out_ready;
  count_vec_t       led_count_o;
  logic             zero_frame;
  logic             err_timeout;

  modport slave (
    input  in_valid, amps_i, amp_sum_i, calc_count, calc_valid, out_ready,
    output in_ready, calc_start, calc_amps, calc_sum, out_valid, led_count_o,
           zero_frame, err_timeout
  );

  modport master (
    output in_valid, amps_i, amp_sum_i, calc_count, calc_valid, out_ready,
    input  in_ready, calc_start, calc_amps, calc_sum, out_valid, led_count_o,
           zero_frame, err_timeout
  );

endinterface

// File: rtl/led_count_ctrl_fixup.sv
// Rounding corrector: nudges one bin per cycle, round-robin from start_ptr,
// until the residual diff is zero or a whole pass makes no progress.
module led_count_fixup
  import led_count_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IDXW-1:0]         start_ptr,
  input  logic signed [DIFFW-1:0] diff_init,
  input  amp_vec_t                amps,
  input  count_vec_t              counts,
  output count_vec_t              counts_next,
  output logic                    done
);

  logic                    busy;
  logic [IDXW-1:0]         ptr;
  logic signed [DIFFW-1:0] diff;
  logic [IDXW:0]           stall_cnt;
  logic                    inc;
  logic                    dec;
  logic                    diff_pos;
  logic                    diff_neg;

  // Silent bins never receive extra LEDs, and a saturated bin never wraps.
  always_comb begin
    inc         = 1'b0;
    dec         = 1'b0;
    counts_next = counts;
    diff_neg    = diff[DIFFW-1];
    diff_pos    = !diff[DIFFW-1] && (diff != '0);
    done        = busy && ((diff == '0) || (stall_cnt == (IDXW+1)'(BIN_QTY)));
    if (busy && !done) begin
      if (diff_pos && (amps[ptr] != '0) && (counts[ptr] != '1)) begin
        inc = 1'b1;
      end else if (diff_neg && (counts[ptr] != '0)) begin
        dec = 1'b1;
      end
    end
    if (inc) begin
      counts_next[ptr] = counts[ptr] + CW'(1);
    end else if (dec) begin
      counts_next[ptr] = counts[ptr] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy      <= 1'b0;
      ptr       <= '0;
      diff      <= '0;
      stall_cnt <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      ptr       <= start_ptr;
      diff      <= diff_init;
      stall_cnt <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        ptr <= next_idx(ptr);
        if (inc) begin
          diff      <= diff - DIFFW'(1);
          stall_cnt <= '0;
        end else if (dec) begin
          diff      <= diff + DIFFW'(1);
          stall_cnt <= '0;
        end else begin
          stall_cnt <= stall_cnt + (IDXW+1)'(1);
        end
      end
    end
  end

endmodule

// File: rtl/led_count_ctrl.sv
// Frame sequencer around the LED-count divider: launch, capture, fix rounding
// so counts sum to LEDS, and hand the result downstream.
module led_count_ctrl
  import led_count_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  led_count_ctrl_if.slave  bus
);

  state_t                  state;
  state_t                  state_nxt;
  amp_vec_t                calc_amps_q;
  logic [SUMW-1:0]         calc_sum_q;
  count_vec_t              work;
  count_vec_t              fix_counts;
  logic                    zero_q;
  logic [IDXW-1:0]         rr_ptr;
  logic [TMOW-1:0]         tmo_cnt;
  logic                    tmo_hit;
  logic                    fix_done;
  logic [TOTW-1:0]         total;
  logic signed [DIFFW-1:0] diff_init;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = (tmo_cnt == TMOW'(TIMEOUT - 1));
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (bus.amp_sum_i == '0) ? OUT : LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        if (bus.calc_valid) begin
          state_nxt = SUM;
        end else if (tmo_hit) begin
          state_nxt = OUT;
        end
      end
      SUM:     state_nxt = FIX;
      FIX:     if (fix_done) state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Residual computed against the freshly captured divider counts.
  always_comb begin
    total = '0;
    for (int i = 0; i < BIN_QTY; i++) begin
      total = total + TOTW'(work[i]);
    end
    diff_init = DIFFW'(LEDS) - DIFFW'(total);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      calc_amps_q <= '0;
      calc_sum_q  <= '0;
      work        <= '0;
      zero_q      <= 1'b0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            calc_amps_q <= bus.amps_i;
            calc_sum_q  <= bus.amp_sum_i;
            zero_q      <= (bus.amp_sum_i == '0);
            if (bus.amp_sum_i == '0) begin
              work <= '0;
            end
          end
        end
        LAUNCH: tmo_cnt <= '0;
        WAIT: begin
          if (bus.calc_valid) begin
            work <= bus.calc_count;
          end else if (tmo_hit) begin
            work <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMOW'(1);
          end
        end
        FIX: if (!fix_done) work <= fix_counts;
        OUT: if (bus.out_ready) rr_ptr <= next_idx(rr_ptr);
        default: ;
      endcase
    end
  end

  led_count_fixup u_fixup (
    .clk         (clk),
    .rst         (rst),
    .start       (state == SUM),
    .start_ptr   (rr_ptr),
    .diff_init   (diff_init),
    .amps        (calc_amps_q),
    .counts      (work),
    .counts_next (fix_counts),
    .done        (fix_done)
  );

  assign bus.in_ready    = (state == IDLE);
  assign bus.calc_start  = (state == LAUNCH);
  assign bus.calc_amps   = calc_amps_q;
  assign bus.calc_sum    = calc_sum_q;
  assign bus.out_valid   = (state == OUT);
  assign bus.led_count_o = work;
  assign bus.zero_frame  = zero_q;
  assign bus.err_timeout = (state == WAIT) && !bus.calc_valid && tmo_hit;

endmodule

// File: tb/tb_led_count_ctrl.sv
// Directed bench for led_count_ctrl: each task drives one scenario and checks
// hand-computed counts, handshakes and round-robin placement of leftover LEDs.
module tb_led_count_ctrl;
  import led_count_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [AW-1:0]   ONE      = 16'h0400;
  localparam logic [SUMW-1:0] SUM_FULL = 20'h03000;

  always #5 clk = ~clk;

  led_count_ctrl_if bus();

  led_count_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic count_vec_t uniform(input int v);
    count_vec_t c;
    for (int i = 0; i < BIN_QTY; i++) c[i] = CW'(v);
    return c;
  endfunction

  function automatic amp_vec_t uniform_amps(input logic [AW-1:0] a);
    amp_vec_t v;
    for (int i = 0; i < BIN_QTY; i++) v[i] = a;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input amp_vec_t a, input logic [SUMW-1:0] s);
    bus.amps_i    = a;
    bus.amp_sum_i = s;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
  endtask

  // Divider stand-in: answers 4 cycles after the launch pulse.
  task automatic divider_reply(input count_vec_t c, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.calc_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (seen) begin
      repeat (4) step();
      bus.calc_count = c;
      bus.calc_valid = 1'b1;
      step();
      bus.calc_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (bus.out_valid === 1'b1) break;
      step();
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.amps_i    = uniform_amps(ONE);
    bus.amp_sum_i = SUM_FULL;
    bus.in_valid  = 1'b1;
    repeat (3) step();
    bus.in_valid  = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    vectors++;
    if ({bus.calc_start, bus.out_valid, bus.zero_frame, bus.err_timeout} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b want 0000",
               {bus.calc_start, bus.out_valid, bus.zero_frame, bus.err_timeout});
    end
    vectors++;
    if (bus.led_count_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_counts: got %h want 0", bus.led_count_o);
    end
    vectors++;
    if (bus.calc_amps !== '0 || bus.calc_sum !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_calc_regs: got amps %h sum %h want 0 0", bus.calc_amps, bus.calc_sum);
    end
    rst = 1'b1;
    step();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.calc_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valid_ignored: got in_ready %b calc_start %b want 1 0",
               bus.in_ready, bus.calc_start);
    end
  endtask

  task automatic test_even_split();
    count_vec_t exp;
    bit         seen;
    for (int f = 0; f < 2; f++) begin
      send_frame(uniform_amps(ONE), SUM_FULL);
      vectors++;
      if (bus.calc_start !== 1'b1 || bus.calc_sum !== SUM_FULL || bus.calc_amps !== uniform_amps(ONE)) begin
        miscompares++;
        $display("[TB] FAIL even_launch%0d: got start %b sum %h want 1 %h",
                 f, bus.calc_start, bus.calc_sum, SUM_FULL);
      end
      divider_reply(uniform(4), seen);
      wait_out(40);
      exp        = uniform(4);
      exp[f]     = CW'(5);
      exp[f + 1] = CW'(5);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.led_count_o !== exp) begin
        miscompares++;
        $display("[TB] FAIL even_counts%0d: got valid %b counts %h want 1 %h",
                 f, bus.out_valid, bus.led_count_o, exp);
      end
      vectors++;
      if (bus.zero_frame !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL even_zero_flag%0d: got %b want 0", f, bus.zero_frame);
      end
      drain();
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL even_return_idle%0d: got in_ready %b out_valid %b want 1 0",
                 f, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_single_bin();
    amp_vec_t   a;
    count_vec_t c;
    count_vec_t exp;
    bit         seen;
    a    = '0;
    a[3] = ONE;
    c    = '0;
    c[3] = CW'(51);
    exp  = '0;
    exp[3] = CW'(50);
    send_frame(a, 20'h00400);
    divider_reply(c, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL single_launch: got no calc_start want pulse");
    end
    wait_out(40);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.led_count_o !== exp) begin
      miscompares++;
      $display("[TB] FAIL single_counts: got valid %b counts %h want 1 %h",
               bus.out_valid, bus.led_count_o, exp);
    end
    drain();
  endtask

  task automatic test_zero_frame();
    send_frame('0, '0);
    vectors++;
    if (bus.calc_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_no_launch: got calc_start %b want 0", bus.calc_start);
    end
    wait_out(1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.zero_frame !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL zero_out: got valid %b zero_frame %b want 1 1", bus.out_valid, bus.zero_frame);
    end
    vectors++;
    if (bus.led_count_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL zero_counts: got %h want 0", bus.led_count_o);
    end
    drain();
  endtask

  task automatic test_timeout();
    int         err_cycle;
    count_vec_t exp;
    bit         seen;
    send_frame(uniform_amps(ONE), SUM_FULL);
    err_cycle = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.err_timeout === 1'b1) begin
        err_cycle = k;
        break;
      end
    end
    vectors++;
    if (err_cycle != 16) begin
      miscompares++;
      $display("[TB] FAIL timeout_cycle: got WAIT cycle %0d want 16", err_cycle);
    end
    step();
    vectors++;
    if (bus.err_timeout !== 1'b0 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_out: got err %b valid %b want 0 1", bus.err_timeout, bus.out_valid);
    end
    vectors++;
    if (bus.led_count_o !== '0 || bus.zero_frame !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_counts: got %h zero_frame %b want 0 0", bus.led_count_o, bus.zero_frame);
    end
    drain();
    // rr_ptr has moved past the zero and timeout frames, so leftovers land on 5,6.
    send_frame(uniform_amps(ONE), SUM_FULL);
    divider_reply(uniform(4), seen);
    wait_out(40);
    exp    = uniform(4);
    exp[5] = CW'(5);
    exp[6] = CW'(5);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.led_count_o !== exp) begin
      miscompares++;
      $display("[TB] FAIL timeout_next_frame: got valid %b counts %h want 1 %h",
               bus.out_valid, bus.led_count_o, exp);
    end
    drain();
  endtask

  task automatic test_backpressure();
    count_vec_t exp;
    bit         seen;
    bit         stable;
    bit         blocked;
    send_frame(uniform_amps(ONE), SUM_FULL);
    divider_reply(uniform(4), seen);
    wait_out(40);
    exp    = uniform(4);
    exp[6] = CW'(5);
    exp[7] = CW'(5);
    bus.amps_i    = '0;
    bus.amp_sum_i = '0;
    bus.in_valid  = 1'b1;
    stable  = 1'b1;
    blocked = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.led_count_o !== exp || bus.out_valid !== 1'b1 || bus.zero_frame !== 1'b0) stable = 1'b0;
      if (bus.in_ready !== 1'b0) blocked = 1'b0;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("[TB] FAIL bp_stable: got counts %h valid %b want %h 1", bus.led_count_o, bus.out_valid, exp);
    end
    vectors++;
    if (!blocked) begin
      miscompares++;
      $display("[TB] FAIL bp_in_ready: got in_ready high during hold want 0");
    end
    drain();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.calc_sum !== SUM_FULL || bus.zero_frame !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_not_consumed: got in_ready %b sum %h zero %b want 1 %h 0",
               bus.in_ready, bus.calc_sum, bus.zero_frame, SUM_FULL);
    end
  endtask

  task automatic test_reset_in_wait();
    count_vec_t exp;
    bit         seen;
    bit         any_out;
    send_frame(uniform_amps(ONE), SUM_FULL);
    vectors++;
    if (bus.calc_start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstwait_launch: got calc_start %b want 1", bus.calc_start);
    end
    repeat (2) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.calc_count = uniform(4);
    bus.calc_valid = 1'b1;
    step();
    bus.calc_valid = 1'b0;
    any_out = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid !== 1'b0) any_out = 1'b1;
      step();
    end
    vectors++;
    if (any_out) begin
      miscompares++;
      $display("[TB] FAIL rstwait_no_out: got out_valid 1 want 0");
    end
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.calc_sum !== '0) begin
      miscompares++;
      $display("[TB] FAIL rstwait_idle: got in_ready %b sum %h want 1 0", bus.in_ready, bus.calc_sum);
    end
    // Reset also rewinds rr_ptr, so leftovers go back to bins 0,1.
    send_frame(uniform_amps(ONE), SUM_FULL);
    divider_reply(uniform(4), seen);
    wait_out(40);
    exp    = uniform(4);
    exp[0] = CW'(5);
    exp[1] = CW'(5);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.led_count_o !== exp) begin
      miscompares++;
      $display("[TB] FAIL rstwait_next_frame: got valid %b counts %h want 1 %h",
               bus.out_valid, bus.led_count_o, exp);
    end
    drain();
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.amps_i     = '0;
    bus.amp_sum_i  = '0;
    bus.calc_count = '0;
    bus.calc_valid = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_even_split();
    test_single_bin();
    test_zero_frame();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
